// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the default byte width
// used by the receiver, transmitter and arbiter.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_RELEASE = 2'd2
   } uart_arb_state_e;

   localparam int UART_DATA_SIZE = 8;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: the first requester at or after rr_ptr+1,
// wrapping modulo NUM_REQ. It is kept separate so other UART muxes can reuse it.
module uart_rr_picker
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               found,
   output logic [ID_W-1:0]    winner
);

   logic [ID_W-1:0] idx_s;
   logic            hit_s;

   // Scan from the farthest candidate to the nearest, so the nearest hit wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx_s  = '0;
      hit_s  = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx_s  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         hit_s  = req[idx_s];
         found  = found | hit_s;
         winner = hit_s ? idx_s : winner;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// producers. A per-requester lock keeps multi-byte frames contiguous.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_SIZE = UART_DATA_SIZE,
   parameter int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ-1:0]           lock,
   input  logic [NUM_REQ*DATA_SIZE-1:0] din,
   output logic [NUM_REQ-1:0]           ack,
   output logic [DATA_SIZE-1:0]         tx_data,
   output logic                         tx_send_req,
   input  logic                         tx_send_ack,
   output logic [ID_W-1:0]              grant_id,
   output logic                         busy
);

   uart_arb_state_e          state_q, state_d;
   logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic                     lock_hold_q, lock_hold_d;
   logic [ID_W-1:0]          grant_id_q, grant_id_d;
   logic [DATA_SIZE-1:0]     tx_data_q, tx_data_d;
   logic [NUM_REQ-1:0]       ack_q, ack_d;
   logic                     tx_send_req_q, tx_send_req_d;
   logic                     busy_q, busy_d;

   logic                     pick_found_s;
   logic [ID_W-1:0]          pick_winner_s;
   logic                     grant_s;
   logic [ID_W-1:0]          win_id_s;

   uart_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .found  (pick_found_s),
      .winner (pick_winner_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= ID_W'(NUM_REQ - 1);
         lock_hold_q   <= 1'b0;
         grant_id_q    <= '0;
         tx_data_q     <= '0;
         ack_q         <= '0;
         tx_send_req_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         lock_hold_q   <= lock_hold_d;
         grant_id_q    <= grant_id_d;
         tx_data_q     <= tx_data_d;
         ack_q         <= ack_d;
         tx_send_req_q <= tx_send_req_d;
         busy_q        <= busy_d;
      end
   end

   // A held lock restricts IDLE to the owner; once lock drops, round-robin applies at once.
   always_comb begin
      state_d  = state_q;
      grant_s  = 1'b0;
      win_id_s = grant_id_q;
      case (state_q)
         ST_IDLE: begin
            if (lock_hold_q && lock[grant_id_q]) begin
               grant_s  = req[grant_id_q];
               win_id_s = grant_id_q;
            end else begin
               grant_s  = pick_found_s;
               win_id_s = pick_winner_s;
            end
            if (grant_s) begin
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (tx_send_ack) begin
               state_d = ST_RELEASE;
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_RELEASE: begin
            if (!tx_send_ack) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RELEASE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      lock_hold_d = lock_hold_q;
      grant_id_d  = grant_id_q;
      tx_data_d   = tx_data_q;
      ack_d       = '0;
      case (state_q)
         ST_IDLE: begin
            if (lock_hold_q && !lock[grant_id_q]) begin
               lock_hold_d = 1'b0;
            end else begin
               lock_hold_d = lock_hold_q;
            end
            if (grant_s) begin
               tx_data_d  = din[int'(win_id_s)*DATA_SIZE +: DATA_SIZE];
               grant_id_d = win_id_s;
               rr_ptr_d   = win_id_s;
               ack_d      = NUM_REQ'(1) << win_id_s;
            end else begin
               ack_d      = '0;
            end
         end
         ST_SEND: begin
            if (tx_send_ack) begin
               lock_hold_d = lock[grant_id_q];
            end else begin
               lock_hold_d = lock_hold_q;
            end
         end
         ST_RELEASE: begin
            lock_hold_d = lock_hold_q;
         end
         default: begin
            lock_hold_d = 1'b0;
         end
      endcase
      tx_send_req_d = (state_d == ST_SEND);
      busy_d        = (state_d != ST_IDLE);
   end

   assign ack         = ack_q;
   assign tx_data     = tx_data_q;
   assign tx_send_req = tx_send_req_q;
   assign grant_id    = grant_id_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scenario bench for uart_tx_arbiter: a scoreboard of expected grants is
// filled when requests are driven and drained whenever an ack pulse appears.
module tb_uart_tx_arbiter;

   logic        clk         = 1'b0;
   logic        reset       = 1'b1;
   logic [3:0]  req         = 4'b0000;
   logic [3:0]  lock        = 4'b0000;
   logic [31:0] din         = 32'h0000_0000;
   logic [3:0]  ack_o;
   logic [7:0]  tx_data;
   logic        tx_send_req;
   logic        tx_send_ack = 1'b0;
   logic [1:0]  grant_id;
   logic        busy;

   int total = 0;
   int bad   = 0;
   bit auto_ack = 1'b0;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_SIZE(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .lock        (lock),
      .din         (din),
      .ack         (ack_o),
      .tx_data     (tx_data),
      .tx_send_req (tx_send_req),
      .tx_send_ack (tx_send_ack),
      .grant_id    (grant_id),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Every ack pulse must match the oldest expected grant.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (ack_o !== 4'b0000) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected ack=%b id=%0d data=%h, no grant expected", ack_o, grant_id, tx_data);
         end else begin
            e = sb.pop_front();
            if (ack_o !== (4'b0001 << e.id) || grant_id !== e.id || tx_data !== e.data || tx_send_req !== 1'b1) begin
               bad++;
               $display("FAIL sb_grant got ack=%b id=%0d data=%h send_req=%b, want ack=%b id=%0d data=%h send_req=1",
                        ack_o, grant_id, tx_data, tx_send_req, 4'b0001 << e.id, e.id, e.data);
            end
         end
      end
   end

   task automatic cycle();
      @(negedge clk);
      if (auto_ack) tx_send_ack = tx_send_req;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 30) begin
         cycle();
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_idle_timeout busy=%b want 0", nm, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle();
      cycle();
      total += 5;
      if (ack_o !== 4'b0000) begin bad++; $display("FAIL rst_ack got %b want 0000", ack_o); end
      if (tx_send_req !== 1'b0) begin bad++; $display("FAIL rst_send_req got %b want 0", tx_send_req); end
      if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
      if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant_id got %0d want 0", grant_id); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      auto_ack = 1'b0;
      cycle();
      din[23:16] = 8'hA5;
      sb.push_back('{id: 2'd2, data: 8'hA5});
      req = 4'b0100;
      cycle();
      total++;
      if (tx_send_req !== 1'b1 || busy !== 1'b1) begin
         bad++; $display("FAIL single_send got send_req=%b busy=%b want 1 1", tx_send_req, busy);
      end
      cycle();
      total++;
      if (ack_o !== 4'b0000) begin bad++; $display("FAIL single_ack_pulse got %b want 0000", ack_o); end
      req = 4'b0000;
      cycle();
      total++;
      if (tx_send_req !== 1'b1) begin bad++; $display("FAIL single_hold got %b want 1", tx_send_req); end
      tx_send_ack = 1'b1;
      cycle();
      total++;
      if (tx_send_req !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL single_release got send_req=%b busy=%b want 0 1", tx_send_req, busy);
      end
      tx_send_ack = 1'b0;
      cycle();
      total++;
      if (busy !== 1'b0 || grant_id !== 2'd2) begin
         bad++; $display("FAIL single_idle got busy=%b id=%0d want 0 2", busy, grant_id);
      end
   endtask

   task automatic test_rr_all();
      int seen;
      int last;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      din = 32'hD3D2_D1D0;
      for (int k = 0; k < 6; k++) begin
         sb.push_back('{id: 2'(k % 4), data: 8'(8'hD0 + (k % 4))});
      end
      auto_ack = 1'b1;
      req = 4'b1111;
      seen = 0;
      last = 0;
      for (int c = 0; c < 40 && seen < 6; c++) begin
         cycle();
         if (ack_o !== 4'b0000) begin
            seen++;
            if (seen > 1) begin
               total++;
               if (c - last != 3) begin
                  bad++; $display("FAIL rr_spacing got %0d cycles want 3", c - last);
               end
            end
            last = c;
            if (seen == 6) req = 4'b0000;
         end
      end
      total++;
      if (seen != 6) begin bad++; $display("FAIL rr_count got %0d grants want 6", seen); end
      wait_idle("rr");
   endtask

   task automatic test_lock();
      int cnt;
      int n1;
      bit upd1;
      logic [3:0] drop_m;
      auto_ack = 1'b1;
      cycle();
      din[15:8] = 8'h10;
      sb.push_back('{id: 2'd1, data: 8'h10});
      sb.push_back('{id: 2'd1, data: 8'h11});
      sb.push_back('{id: 2'd1, data: 8'h12});
      sb.push_back('{id: 2'd3, data: 8'hD3});
      sb.push_back('{id: 2'd0, data: 8'hD0});
      lock = 4'b0010;
      req  = 4'b0010;
      cnt = 0; n1 = 0; upd1 = 1'b0; drop_m = 4'b0000;
      for (int c = 0; c < 60 && cnt < 5; c++) begin
         cycle();
         if (upd1) begin
            upd1 = 1'b0;
            if (n1 < 3) din[15:8] = 8'(8'h10 + n1);
            else begin req[1] = 1'b0; lock[1] = 1'b0; end
         end
         if (drop_m !== 4'b0000) begin req = req & ~drop_m; drop_m = 4'b0000; end
         if (ack_o !== 4'b0000) begin
            cnt++;
            if (ack_o[1]) begin
               n1++;
               upd1 = 1'b1;
               if (n1 == 1) req = req | 4'b1001;
            end else begin
               drop_m = ack_o;
            end
         end
      end
      total++;
      if (cnt != 5) begin bad++; $display("FAIL lock_count got %0d grants want 5", cnt); end
      req = 4'b0000;
      lock = 4'b0000;
      wait_idle("lock");
   endtask

   task automatic test_level_ack();
      auto_ack = 1'b0;
      cycle();
      sb.push_back('{id: 2'd0, data: 8'hD0});
      req = 4'b0001;
      cycle();
      tx_send_ack = 1'b1;
      cycle();
      total++;
      if (tx_send_req !== 1'b0) begin bad++; $display("FAIL level_req_drop got %b want 0", tx_send_req); end
      din[23:16] = 8'h77;
      sb.push_back('{id: 2'd2, data: 8'h77});
      req = 4'b0100;
      for (int k = 3; k <= 6; k++) begin
         cycle();
         total++;
         if (busy !== 1'b1 || tx_send_req !== 1'b0 || ack_o !== 4'b0000) begin
            bad++; $display("FAIL level_hold_%0d got busy=%b send_req=%b ack=%b want 1 0 0000", k, busy, tx_send_req, ack_o);
         end
         if (k == 6) tx_send_ack = 1'b0;
      end
      cycle();
      total++;
      if (busy !== 1'b0 || tx_send_req !== 1'b0) begin
         bad++; $display("FAIL level_idle got busy=%b send_req=%b want 0 0", busy, tx_send_req);
      end
      cycle();
      total++;
      if (tx_send_req !== 1'b1) begin bad++; $display("FAIL level_next got %b want 1", tx_send_req); end
      tx_send_ack = 1'b1;
      cycle();
      tx_send_ack = 1'b0;
      req = 4'b0000;
      wait_idle("level");
   endtask

   task automatic test_reset_mid();
      auto_ack = 1'b0;
      cycle();
      din[15:8] = 8'h3C;
      sb.push_back('{id: 2'd1, data: 8'h3C});
      req = 4'b0010;
      cycle();
      reset = 1'b1;
      req = 4'b0000;
      cycle();
      total += 5;
      if (tx_send_req !== 1'b0) begin bad++; $display("FAIL midrst_send_req got %b want 0", tx_send_req); end
      if (tx_data !== 8'h00) begin bad++; $display("FAIL midrst_tx_data got %h want 00", tx_data); end
      if (grant_id !== 2'd0) begin bad++; $display("FAIL midrst_grant_id got %0d want 0", grant_id); end
      if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b want 0", busy); end
      if (ack_o !== 4'b0000) begin bad++; $display("FAIL midrst_ack got %b want 0000", ack_o); end
      reset = 1'b0;
      din[31:24] = 8'hE7;
      sb.push_back('{id: 2'd3, data: 8'hE7});
      req = 4'b1000;
      cycle();
      total++;
      if (ack_o !== 4'b1000) begin bad++; $display("FAIL midrst_first_win got %b want 1000", ack_o); end
      tx_send_ack = 1'b1;
      cycle();
      tx_send_ack = 1'b0;
      req = 4'b0000;
      wait_idle("midrst");
   endtask

   task automatic test_lock_starve();
      int stray;
      bit got;
      auto_ack = 1'b1;
      cycle();
      din[23:16] = 8'h55;
      sb.push_back('{id: 2'd2, data: 8'h55});
      lock = 4'b0100;
      req = 4'b0100;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         cycle();
         if (ack_o[2] === 1'b1) got = 1'b1;
      end
      total++;
      if (!got) begin bad++; $display("FAIL starve_owner_grant got none want ack[2]"); end
      cycle();
      req = 4'b0001;
      stray = 0;
      for (int c = 0; c < 20; c++) begin
         cycle();
         if (ack_o !== 4'b0000) stray++;
      end
      total++;
      if (stray != 0 || busy !== 1'b0) begin
         bad++; $display("FAIL starve_hold got %0d grants busy=%b want 0 0", stray, busy);
      end
      sb.push_back('{id: 2'd0, data: 8'hD0});
      lock = 4'b0000;
      cycle();
      total++;
      if (ack_o !== 4'b0001) begin bad++; $display("FAIL starve_release got %b want 0001", ack_o); end
      cycle();
      req = 4'b0000;
      wait_idle("starve");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_rr_all();
      test_lock();
      test_level_ack();
      test_reset_mid();
      test_lock_starve();
      cycle();
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got %0d pending want 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
